// File: rtl/note_sequence_controller.sv
// note_sequence_controller
// Plays a song from an external synchronous event ROM. Each event is
// {note[5:0], len[4:0]}. The block fetches events one at a time, times each
// note in 32nd-note ticks and drives the note code, the gate and a one-cycle
// onset strobe. All outputs are registered.
// Optional build macro: NOTE_GAP_EN. When defined, the gate drops during the
// final tick of notes longer than one tick so repeated notes re-articulate.
module note_sequence_controller #(
  parameter int ADDR_W      = 4,
  parameter int TICK_CYCLES = 781250
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [10:0]       i_rom_data,
  output logic [5:0]        o_note,
  output logic              o_note_valid,
  output logic              o_gate,
  output logic              o_busy,
  output logic              o_done
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [4:0]          len_q, len_d;
  logic [5:0]          note_q, note_d;
  logic                gate_q, gate_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                rom_en_q, rom_en_d;
  logic                busy_q, busy_d;
  logic                start_pend_q, start_pend_d;

  logic [5:0]          ev_note;
  logic [4:0]          ev_len;
  logic                ev_end;
  logic                tick_wrap;

  assign ev_note   = i_rom_data[10:5];
  assign ev_len    = i_rom_data[4:0];
  assign ev_end    = (ev_note == 6'h3F) && (ev_len == 5'h00);
  assign tick_wrap = (tick_q == TICK_LAST);

  // Next-state and next-output computation for the playback FSM.
  // A start pulse seen in IDLE is held for one cycle in start_pend so the
  // first fetch happens one cycle after the start edge; a stop on either
  // cycle cancels it.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tick_d       = tick_q;
    len_d        = len_q;
    note_d       = note_q;
    gate_d       = gate_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    rom_en_d     = 1'b0;
    start_pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        note_d       = 6'h00;
        gate_d       = 1'b0;
        start_pend_d = i_start & ~i_stop & ~start_pend_q;
        if (start_pend_q && !i_stop) begin
          state_d  = S_FETCH;
          addr_d   = '0;
          rom_en_d = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ev_end) begin
          if (i_loop) begin
            // Restart: note and gate hold so the loop seam is silent-free.
            addr_d   = '0;
            rom_en_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          note_d  = ev_note;
          valid_d = 1'b1;
          gate_d  = (ev_note != 6'h00);
          tick_d  = '0;
          len_d   = ev_len;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (len_q != 5'd0) begin
            len_d = len_q - 5'd1;
`ifdef NOTE_GAP_EN
            // Entering the final tick of a multi-tick note: open the gap.
            if (len_q == 5'd1) gate_d = 1'b0;
`endif
          end else begin
            addr_d   = addr_q + 1'b1;
            rom_en_d = 1'b1;
            state_d  = S_FETCH;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        note_d  = 6'h00;
        gate_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stop overrides everything else once playback is underway.
    if (i_stop && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      note_d   = 6'h00;
      gate_d   = 1'b0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      rom_en_d = 1'b0;
      tick_d   = '0;
      len_d    = 5'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tick_q       <= '0;
      len_q        <= 5'd0;
      note_q       <= 6'h00;
      gate_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      rom_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tick_q       <= tick_d;
      len_q        <= len_d;
      note_q       <= note_d;
      gate_q       <= gate_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      rom_en_q     <= rom_en_d;
      busy_q       <= busy_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign o_rom_en     = rom_en_q;
  assign o_rom_addr   = addr_q;
  assign o_note       = note_q;
  assign o_note_valid = valid_q;
  assign o_gate       = gate_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_note_sequence_controller.sv
// Testbench for note_sequence_controller with TICK_CYCLES=4, ADDR_W=4.
// Expected note onsets and done pulses come from a small event-walking model
// pushed into queues; a monitor collects observed events for comparison.
module tb_note_sequence_controller;
  localparam int ADDR_W = 4;
  localparam int T      = 4;
  localparam logic [10:0] END_EV = 11'h7E0;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, loop_l;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [10:0] rom_data;
  logic [5:0]  note;
  logic        note_valid, gate, busy, done;
  logic [10:0] rom [16];

  always #5 clk = ~clk;

  note_sequence_controller #(.ADDR_W(ADDR_W), .TICK_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_loop(loop_l), .o_rom_en(rom_en), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_note(note), .o_note_valid(note_valid),
    .o_gate(gate), .o_busy(busy), .o_done(done)
  );

  // Synchronous ROM; data is garbage except in the cycle after a read.
  always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 11'h555;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [5:0] n;
    logic       g;
  } onset_t;

  onset_t exp_q[$];
  onset_t obs_q[$];
  int     exp_done[$];
  int     obs_done[$];
  int     tests = 0;
  int     fails = 0;

  // Monitor: record every onset strobe and done pulse with its edge number.
  always @(negedge clk) begin
    onset_t o;
    if (note_valid === 1'b1) begin
      o.t = cyc; o.n = note; o.g = gate;
      obs_q.push_back(o);
    end
    if (done === 1'b1) obs_done.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 16; i++) rom[i] = END_EV;
  endtask

  // Model: walk the ROM as the scheduler should, from a start edge t0.
  task automatic build_expected(input bit lp, input int t0, input int horizon);
    int addr, tf, td;
    logic [10:0] ev;
    onset_t o;
    addr = 0;
    tf = t0 + 1;
    for (int k = 0; k < 100; k++) begin
      ev = rom[addr];
      td = tf + 2;
      if (td > horizon) break;
      if (ev == END_EV) begin
        if (lp) begin
          addr = 0; tf = td;
        end else begin
          exp_done.push_back(td + 1);
          break;
        end
      end else begin
        o.t = td; o.n = ev[10:5]; o.g = (ev[10:5] != 6'h00);
        exp_q.push_back(o);
        tf = td + (int'(ev[4:0]) + 1) * T;
        addr = (addr + 1) % 16;
      end
    end
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_l = 1'b0;
    fill_rom();
    repeat (3) @(negedge clk);
    tests++;
    if ({rom_en, rom_addr, note, note_valid, gate, busy, done} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rom_en, rom_addr, note, note_valid, gate, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_note();
    int t0;
    fill_rom(); clear_q();
    rom[0] = {6'h0A, 5'd1};
    pulse_start(t0);
    build_expected(1'b0, t0, t0 + 40);
    @(negedge clk);
    tests++;
    if ({rom_en, rom_addr, busy} !== {1'b1, 4'h0, 1'b1}) begin
      fails++;
      $display("FAIL single_fetch: got en=%b addr=%h busy=%b expected 1 0 1", rom_en, rom_addr, busy);
    end
    run_to(t0 + 20);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL single_onset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].n !== exp_q[i].n || obs_q[i].g !== exp_q[i].g) begin
        fails++;
        $display("FAIL single_onset%0d: got t=%0d n=%h g=%b expected t=%0d n=%h g=%b", i,
                 obs_q[i].t - t0, obs_q[i].n, obs_q[i].g, exp_q[i].t - t0, exp_q[i].n, exp_q[i].g);
      end
    end
    tests++;
    if (obs_done.size() != 1 || obs_done[0] !== exp_done[0]) begin
      fails++; $display("FAIL single_done: got %0d pulses expected 1 at +%0d", obs_done.size(), exp_done[0] - t0);
    end
    tests++;
    if ({busy, gate, note} !== 8'h00) begin
      fails++; $display("FAIL single_idle_after: got busy=%b gate=%b note=%h expected 0", busy, gate, note);
    end
  endtask

  task automatic test_rest_spacing();
    int t0;
    fill_rom(); clear_q();
    rom[0] = {6'h05, 5'd0}; rom[1] = {6'h00, 5'd2}; rom[2] = {6'h07, 5'd0};
    pulse_start(t0);
    build_expected(1'b0, t0, t0 + 60);
    run_to(t0 + 15);
    tests++;
    if ({gate, note} !== 7'h00) begin
      fails++; $display("FAIL rest_gate: got gate=%b note=%h expected 0 00", gate, note);
    end
    run_to(t0 + 40);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rest_onset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].n !== exp_q[i].n || obs_q[i].g !== exp_q[i].g) begin
        fails++;
        $display("FAIL rest_onset%0d: got t=%0d n=%h g=%b expected t=%0d n=%h g=%b", i,
                 obs_q[i].t - t0, obs_q[i].n, obs_q[i].g, exp_q[i].t - t0, exp_q[i].n, exp_q[i].g);
      end
    end
    tests++;
    if (obs_done.size() != 1 || obs_done[0] !== exp_done[0]) begin
      fails++; $display("FAIL rest_done: got %0d pulses expected 1 at +%0d", obs_done.size(), exp_done[0] - t0);
    end
  endtask

  task automatic test_loop();
    int t0;
    fill_rom(); clear_q();
    rom[0] = {6'h11, 5'd0}; rom[1] = {6'h12, 5'd1};
    loop_l = 1'b1;
    pulse_start(t0);
    run_to(t0 + 45);
    build_expected(1'b1, t0, t0 + 45);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_l = 1'b0;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL loop_onset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].n !== exp_q[i].n || obs_q[i].g !== exp_q[i].g) begin
        fails++;
        $display("FAIL loop_onset%0d: got t=%0d n=%h g=%b expected t=%0d n=%h g=%b", i,
                 obs_q[i].t - t0, obs_q[i].n, obs_q[i].g, exp_q[i].t - t0, exp_q[i].n, exp_q[i].g);
      end
    end
    tests++;
    if (obs_done.size() != 0) begin
      fails++; $display("FAIL loop_no_done: got %0d pulses expected 0", obs_done.size());
    end
    tests++;
    if ({busy, gate, note} !== 8'h00) begin
      fails++; $display("FAIL loop_stop: got busy=%b gate=%b note=%h expected 0", busy, gate, note);
    end
  endtask

  task automatic test_stop_mid_note();
    int t0, t1;
    fill_rom(); clear_q();
    rom[0] = {6'h0A, 5'd3};
    pulse_start(t0);
    run_to(t0 + 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++;
    if ({busy, gate, note, note_valid} !== 9'h000) begin
      fails++; $display("FAIL stop_outputs: got busy=%b gate=%b note=%h valid=%b expected 0", busy, gate, note, note_valid);
    end
    run_to(t0 + 30);
    tests++;
    if (obs_done.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL stop_no_done: got done=%0d busy=%b expected 0 0", obs_done.size(), busy);
    end
    clear_q();
    pulse_start(t1);
    build_expected(1'b0, t1, t1 + 3);
    @(negedge clk);
    tests++;
    if ({rom_en, rom_addr} !== 5'b1_0000) begin
      fails++; $display("FAIL stop_restart_addr: got en=%b addr=%h expected 1 0", rom_en, rom_addr);
    end
    run_to(t1 + 4);
    tests++;
    if (obs_q.size() != 1 || obs_q[0].t !== exp_q[0].t || obs_q[0].n !== exp_q[0].n) begin
      fails++; $display("FAIL stop_restart_onset: got %0d onsets expected 1 note %h at +3", obs_q.size(), exp_q[0].n);
    end
    run_to(t1 + 26);
  endtask

  task automatic test_reset_mid_play();
    int t0;
    fill_rom(); clear_q();
    rom[0] = {6'h0A, 5'd3};
    pulse_start(t0);
    run_to(t0 + 6);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({rom_en, rom_addr, note, note_valid, gate, busy, done} !== 15'h0) begin
      fails++;
      $display("FAIL reset_mid_play: got %h expected 0", {rom_en, rom_addr, note, note_valid, gate, busy, done});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({busy, gate} !== 2'b00) begin
      fails++; $display("FAIL reset_stays_idle: got busy=%b gate=%b expected 0 0", busy, gate);
    end
  endtask

  task automatic test_start_while_busy();
    int t0;
    fill_rom(); clear_q();
    rom[0] = {6'h05, 5'd1}; rom[1] = {6'h06, 5'd0};
    pulse_start(t0);
    build_expected(1'b0, t0, t0 + 60);
    run_to(t0 + 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to(t0 + 11);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to(t0 + 30);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL busy_onset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].n !== exp_q[i].n || obs_q[i].g !== exp_q[i].g) begin
        fails++;
        $display("FAIL busy_onset%0d: got t=%0d n=%h g=%b expected t=%0d n=%h g=%b", i,
                 obs_q[i].t - t0, obs_q[i].n, obs_q[i].g, exp_q[i].t - t0, exp_q[i].n, exp_q[i].g);
      end
    end
    tests++;
    if (obs_done.size() != 1 || obs_done[0] !== exp_done[0] || busy !== 1'b0) begin
      fails++; $display("FAIL busy_done: got %0d pulses busy=%b expected 1 at +%0d busy 0",
                        obs_done.size(), busy, exp_done[0] - t0);
    end
  endtask

  task automatic test_start_stop_idle();
    clear_q();
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      fails++; $display("FAIL start_stop_idle: got busy=%b onsets=%0d expected 0 0", busy, obs_q.size());
    end
  endtask

  task automatic test_addr_wrap_gate();
    int t0, highs, bad_note;
    logic exp_hold;
    int exp_highs;
`ifdef NOTE_GAP_EN
    exp_highs = 12; exp_hold = 1'b0;
`else
    exp_highs = 16; exp_hold = 1'b1;
`endif
    clear_q();
    rom[0] = {6'h0A, 5'd3};
    for (int i = 1; i < 16; i++) rom[i] = {6'(6'h10 + i), 5'd0};
    pulse_start(t0);
    run_to(t0 + 3);
    highs = 0; bad_note = 0;
    for (int i = 0; i < 16; i++) begin
      if (gate === 1'b1) highs++;
      if (note !== 6'h0A) bad_note++;
      @(negedge clk);
    end
    tests++;
    if (highs != exp_highs || bad_note != 0) begin
      fails++; $display("FAIL gate_len: got high=%0d bad_note=%0d expected %0d 0", highs, bad_note, exp_highs);
    end
    tests++;
    if (gate !== exp_hold || note !== 6'h0A) begin
      fails++; $display("FAIL gate_hold_fetch: got gate=%b note=%h expected %b 0a", gate, note, exp_hold);
    end
    run_to(t0 + 115);
    build_expected(1'b0, t0, t0 + 115);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL wrap_onset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].n !== exp_q[i].n || obs_q[i].g !== exp_q[i].g) begin
        fails++;
        $display("FAIL wrap_onset%0d: got t=%0d n=%h g=%b expected t=%0d n=%h g=%b", i,
                 obs_q[i].t - t0, obs_q[i].n, obs_q[i].g, exp_q[i].t - t0, exp_q[i].n, exp_q[i].g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest_spacing();
    test_loop();
    test_stop_mid_note();
    test_reset_mid_play();
    test_start_while_busy();
    test_start_stop_idle();
    test_addr_wrap_gate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_sequence_controller.md
# note_sequence_controller

Scheduler that plays a song stored in an external synchronous event ROM. It fetches one note event at a time, times each note in 32nd-note ticks, and drives the note code into the note table / PWM datapath. It also generates a gate signal and a one-cycle note-onset strobe. It sits between the top-level play/stop controls and the note-table lookup, replacing hard-wired note index sequencing.

## Interface
- `ADDR_W`, 4: event ROM address width; song holds up to 2^ADDR_W events.
- `TICK_CYCLES`, 781250: clocks per 32nd-note tick (31.25 ms at 25 MHz); minimum 2.

- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_start` input 1: pulse; begins playback from address 0 when idle.
- `i_stop` input 1: pulse; aborts playback.
- `i_loop` input 1: level; sampled at end marker, restarts song when high.
- `o_rom_en` output 1: ROM read enable.
- `o_rom_addr` output ADDR_W: ROM read address.
- `i_rom_data` input 11: event `{note[5:0], len[4:0]}`, valid the cycle after `o_rom_en`.
- `o_note` output 6: current note code to note table; 6'h00 = rest.
- `o_note_valid` output 1: one-cycle pulse when `o_note` takes a new event.
- `o_gate` output 1: high while a non-rest note sounds.
- `o_busy` output 1: high in any state other than IDLE.
- `o_done` output 1: one-cycle pulse at non-looping end of song.

## Operation
- Event encoding:
  - `len` = duration−1 in 32nd ticks (0..31 → 1..32 ticks).
  - `note` 6'h3F with `len` 5'h00 is the END marker.
  - `note` 6'h00 is a rest.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE:
  - `i_start` → FETCH with address 0.
  - In IDLE, `o_note`=0 and `o_gate`=0.
- FETCH: `o_rom_en`=1 and `o_rom_addr`=current address for exactly one cycle → LOAD.
- LOAD, decoding `i_rom_data`:
  - END marker with `i_loop`=1: address←0, → FETCH; `o_note` and `o_gate` hold.
  - END marker with `i_loop`=0: → DONE.
  - Otherwise: `o_note`←note, `o_note_valid` pulses, `o_gate`←(note≠0), tick counter←0, length counter←len, → PLAY.
- PLAY:
  - Tick counter counts 0..TICK_CYCLES−1.
  - At wrap with length counter≠0: decrement the length counter.
  - At wrap with length counter=0: address←address+1 (wraps modulo 2^ADDR_W), → FETCH.
- DONE:
  - `o_done` pulses for 1 cycle; `o_note`←0, `o_gate`←0, → IDLE.
- `i_stop` (any non-IDLE state):
  - Next state IDLE; `o_note`←0 and `o_gate`←0 on the same edge.
  - No `o_done` pulse.
  - Stop has priority over start, tick wrap and LOAD decode.
- `i_start` while busy is ignored.
- `i_start` and `i_stop` together while idle: stay IDLE.
- Reset (any state, mid-note included): IDLE, address 0, all counters 0, every output 0.

## Timing
- `i_start` sampled at edge N:
  - FETCH during cycle N+1.
  - LOAD during cycle N+2.
  - `o_note`/`o_note_valid`/`o_gate` update at edge N+3.
- Note onset-to-onset spacing: exactly (len+1)·TICK_CYCLES + 2 clocks. The 2 extra clocks are FETCH and LOAD.
- `o_note` and `o_gate` hold across FETCH/LOAD between notes, so there is no audible glitch.
- Loop restart costs 4 clocks beyond the last note: FETCH/LOAD of the END marker, then FETCH/LOAD of event 0.
- All outputs are registered; no combinational path from inputs to outputs.
- ROM contract: synchronous read, 1-cycle latency, data held only in the cycle after `o_rom_en`.

## Configuration
- Macro: `NOTE_GAP_EN` (articulation gap).
- Defined:
  - For events with len≥1, `o_gate` deasserts for the final tick, i.e. while the length counter=0 in PLAY.
  - `o_note` is unchanged during the gap.
  - Repeated identical notes are therefore re-articulated.
  - Events with len=0 keep the gate high for the whole tick.
- Undefined: `o_gate` stays equal to (note≠0) for the whole PLAY and holds through FETCH/LOAD.

## Test plan
Benches use TICK_CYCLES=4 and ADDR_W=4.

1. Single note:
   - Stimulus: ROM {0x0A,1}, END; `i_loop`=0; start pulse at edge 0.
   - Response: at edge 3, `o_note_valid` pulses and `o_note`=0x0A, `o_gate`=1. `o_done` pulses 8+2+1 clocks later, then `o_busy`=0 and `o_gate`=0.
2. Rest and spacing:
   - Stimulus: ROM {0x05,0},{0x00,2},{0x07,0}, END.
   - Response: onsets spaced 6 and 14 clocks; `o_gate`=0 only during the rest.
3. Loop:
   - Stimulus: `i_loop`=1 with a two-event song.
   - Response: event 0 re-onsets 4 clocks after the last note's final tick; `o_done` never pulses.
4. Stop mid-note:
   - Stimulus: `i_stop` during PLAY tick 2.
   - Response: next edge gives IDLE, `o_note`=0, `o_gate`=0, no `o_done`. A following `i_start` replays from address 0.
5. Reset and start-while-busy:
   - Stimulus: assert `i_rst_n`=0 for 1 cycle mid-PLAY; separately pulse `i_start` during PLAY.
   - Response: reset gives all outputs 0. Start-while-busy leaves timing unchanged.
6. `NOTE_GAP_EN` build:
   - Stimulus: event {0x0A,3}.
   - Response: `o_gate` high 12 clocks, low 4 clocks, `o_note` stays 0x0A. Address wraps from 15 to 0 when no END is present.
